// File: rtl/sig_check_pkg.sv
// Shared types for the BIST signature checker: FSM state encoding and
// the X value used to flag unreachable encodings in the next-state logic.
package sig_check_pkg;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'b00,
        CHK_RUN  = 2'b01,
        CHK_DONE = 2'b10
    } st_chk_state;

    localparam st_chk_state CHK_STATEX = st_chk_state'(2'bxx);

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO holding golden signatures. Flush empties it in
// one cycle; pop on empty and push on full are ignored.
module sync_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/signature_checker.sv
// Compares each analyzer signature against the oldest preloaded golden value
// and keeps per-session test/fail tallies, first syndrome and pass/fail.
module signature_checker
    import sig_check_pkg::*;
#(
    parameter int DATA_WIDTH = 54,
    parameter int CNT_WIDTH  = 8,
    parameter int GOLD_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_num_tests,
    input  logic                  i_gold_vld,
    input  logic [DATA_WIDTH-1:0] i_gold_data,
    output logic                  o_gold_rdy,
    input  logic                  i_sig_vld,
    input  logic [DATA_WIDTH-1:0] i_sig_data,
    output logic                  o_busy,
    output logic                  o_cmp_vld,
    output logic                  o_cmp_match,
    output logic [CNT_WIDTH-1:0]  o_test_cnt,
    output logic [CNT_WIDTH-1:0]  o_fail_cnt,
    output logic                  o_err_underflow,
    output logic [DATA_WIDTH-1:0] o_first_syn,
    output logic                  o_done,
    output logic                  o_pass
);

    st_chk_state           state;
    st_chk_state           state_next;
    logic                  start_ok;
    logic                  consume;
    logic                  last_sig;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] gold_head;
    logic [CNT_WIDTH-1:0]  num_tests;
    logic [CNT_WIDTH-1:0]  test_cnt_inc;
    logic [CNT_WIDTH-1:0]  fail_cnt_inc;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (GOLD_DEPTH)
    ) u_gold_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (start_ok),
        .i_push  (i_gold_vld && o_gold_rdy),
        .i_data  (i_gold_data),
        .i_pop   (consume),
        .o_data  (gold_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign test_cnt_inc = o_test_cnt + CNT_WIDTH'(1);
    assign fail_cnt_inc = (o_fail_cnt == '1) ? o_fail_cnt : o_fail_cnt + CNT_WIDTH'(1);
    assign last_sig     = consume && (test_cnt_inc == num_tests);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= CHK_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CHK_IDLE, CHK_DONE: begin
                if (i_start) begin
                    state_next = (i_num_tests == '0) ? CHK_DONE : CHK_RUN;
                end
            end
            CHK_RUN: begin
                if (last_sig) begin
                    state_next = CHK_DONE;
                end
            end
            default: state_next = CHK_STATEX;
        endcase
    end

    always_comb begin
        o_busy     = (state == CHK_RUN);
        o_done     = (state == CHK_DONE);
        o_gold_rdy = (state == CHK_RUN) && !fifo_full;
        start_ok   = i_start && ((state == CHK_IDLE) || (state == CHK_DONE));
        consume    = i_sig_vld && (state == CHK_RUN);
        o_pass     = (state == CHK_DONE) && (o_fail_cnt == '0) && !o_err_underflow;
    end

    // An empty FIFO at signature time counts as a failure but leaves the
    // syndrome alone; the syndrome only latches while no failure is on record.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            num_tests       <= '0;
            o_cmp_vld       <= 1'b0;
            o_cmp_match     <= 1'b0;
            o_test_cnt      <= '0;
            o_fail_cnt      <= '0;
            o_err_underflow <= 1'b0;
            o_first_syn     <= '0;
        end else begin
            o_cmp_vld <= 1'b0;
            if (start_ok) begin
                num_tests       <= i_num_tests;
                o_cmp_match     <= 1'b0;
                o_test_cnt      <= '0;
                o_fail_cnt      <= '0;
                o_err_underflow <= 1'b0;
                o_first_syn     <= '0;
            end else if (consume) begin
                o_cmp_vld  <= 1'b1;
                o_test_cnt <= test_cnt_inc;
                if (fifo_empty) begin
                    o_cmp_match     <= 1'b0;
                    o_fail_cnt      <= fail_cnt_inc;
                    o_err_underflow <= 1'b1;
                end else if (i_sig_data == gold_head) begin
                    o_cmp_match <= 1'b1;
                end else begin
                    o_cmp_match <= 1'b0;
                    o_fail_cnt  <= fail_cnt_inc;
                    if (o_fail_cnt == '0) begin
                        o_first_syn <= i_sig_data ^ gold_head;
                    end
                end
            end
        end
    end

endmodule
